// File: rtl/gray_bin_conv_pipe.sv
// Two-stage pipelined Gray<->binary converter with valid/ready handshake.
// Gray->binary words are also checked for single-bit steps against the
// previously accepted Gray word; violations are flagged per word and counted.
module gray_bin_conv_pipe #(
    parameter int DATA_WID = 4,
    parameter int CNT_WID  = 8,
    parameter int CHECK_EN = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                In_Valid,
    output logic                In_Ready,
    input  logic                Mode,
    input  logic [DATA_WID-1:0] Data_In,
    output logic                Out_Valid,
    input  logic                Out_Ready,
    output logic [DATA_WID-1:0] Data_Out,
    output logic                Out_Err,
    output logic [CNT_WID-1:0]  Err_Cnt
);

    localparam logic                LP_CHK     = (CHECK_EN != 0);
    localparam logic [DATA_WID-1:0] LP_ONE     = {{(DATA_WID-1){1'b0}}, 1'b1};
    localparam logic [CNT_WID-1:0]  LP_CNT_ONE = {{(CNT_WID-1){1'b0}}, 1'b1};
    localparam logic [CNT_WID-1:0]  LP_CNT_MAX = '1;

    // Stage 1: raw input word, its mode and its sequence-error flag
    logic                r_s1_valid;
    logic [DATA_WID-1:0] r_s1_data;
    logic                r_s1_mode;
    logic                r_s1_err;

    // Stage 2: converted result presented on the output
    logic                r_s2_valid;
    logic [DATA_WID-1:0] r_s2_data;
    logic                r_s2_err;

    // Sequence checker state
    logic [DATA_WID-1:0] r_hist;
    logic                r_hist_valid;
    logic [CNT_WID-1:0]  r_err_cnt;

    logic                w_s2_load;
    logic                w_in_ready;
    logic                w_in_xfer;
    logic [DATA_WID-1:0] w_diff;
    logic                w_one_step;
    logic                w_flag;
    logic [DATA_WID-1:0] w_conv;

    // S2 may load when empty or when its word leaves this cycle; S1 follows it.
    assign w_s2_load  = !r_s2_valid || Out_Ready;
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_in_xfer  = In_Valid && w_in_ready;

    // Exactly one bit set in the difference <=> legal Gray step (x & (x-1) clears the lowest set bit).
    assign w_diff     = Data_In ^ r_hist;
    assign w_one_step = (w_diff != '0) && ((w_diff & (w_diff - LP_ONE)) == '0);
    assign w_flag     = LP_CHK && !Mode && r_hist_valid && !w_one_step;

    // Conversion of the S1 word; Gray->binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        w_conv = '0;
        if (r_s1_mode) begin
            w_conv = r_s1_data ^ (r_s1_data >> 1);
        end else begin
            for (int unsigned i = 0; i < DATA_WID; i++) begin
                w_conv[i] = ^(r_s1_data >> i);
            end
        end
    end

    // Stage 1 capture on input transfer; empties when its word moves on without a refill.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_err   <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= Data_In;
            r_s1_mode  <= Mode;
            r_s1_err   <= w_flag;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2 load of the converted word; held while the consumer stalls.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_conv;
                r_s2_err  <= r_s1_err;
            end
        end
    end

    // History of the last accepted Gray word; a binary->Gray word breaks the sequence.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_hist       <= '0;
            r_hist_valid <= 1'b0;
        end else if (w_in_xfer) begin
            if (Mode) begin
                r_hist_valid <= 1'b0;
            end else begin
                r_hist       <= Data_In;
                r_hist_valid <= 1'b1;
            end
        end
    end

    // Saturating error count, bumped when a flagged word is accepted at the input.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_err_cnt <= '0;
        end else if (w_in_xfer && w_flag && (r_err_cnt != LP_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + LP_CNT_ONE;
        end
    end

    assign In_Ready  = w_in_ready;
    assign Out_Valid = r_s2_valid;
    assign Data_Out  = r_s2_data;
    assign Out_Err   = r_s2_err;
    assign Err_Cnt   = r_err_cnt;

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Self-checking bench: transaction-level model plus directed vectors with
// hand-computed expectations. Three DUT copies share the stimulus: default
// parameters, a 2-bit error counter, and the checker disabled.
module tb_gray_bin_conv_pipe;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          out_ready = 1'b1;

    logic          in_ready, out_valid, out_err;
    logic [DW-1:0] data_out;
    logic [7:0]    err_cnt;

    logic          s_in_ready, s_out_valid, s_out_err;
    logic [DW-1:0] s_data_out;
    logic [1:0]    s_err_cnt;

    logic          n_in_ready, n_out_valid, n_out_err;
    logic [DW-1:0] n_data_out;
    logic [7:0]    n_err_cnt;

    gray_bin_conv_pipe #(.DATA_WID(DW), .CNT_WID(8), .CHECK_EN(1)) u_dut (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(in_ready), .Mode(mode),
        .Data_In(data_in), .Out_Valid(out_valid), .Out_Ready(out_ready),
        .Data_Out(data_out), .Out_Err(out_err), .Err_Cnt(err_cnt));

    gray_bin_conv_pipe #(.DATA_WID(DW), .CNT_WID(2), .CHECK_EN(1)) u_sat (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(s_in_ready), .Mode(mode),
        .Data_In(data_in), .Out_Valid(s_out_valid), .Out_Ready(out_ready),
        .Data_Out(s_data_out), .Out_Err(s_out_err), .Err_Cnt(s_err_cnt));

    gray_bin_conv_pipe #(.DATA_WID(DW), .CNT_WID(8), .CHECK_EN(0)) u_nochk (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(n_in_ready), .Mode(mode),
        .Data_In(data_in), .Out_Valid(n_out_valid), .Out_Ready(out_ready),
        .Data_Out(n_data_out), .Out_Err(n_out_err), .Err_Cnt(n_err_cnt));

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            acc;
    } word_t;

    word_t         mq[$];
    logic [DW-1:0] m_hist = '0;
    bit            m_hist_v = 0;
    int            m_cnt = 0;
    int            m_cnt_sat = 0;
    int            cyc = 0;
    bit            live = 0;

    // Binary value whose Gray code is g, found by search.
    function automatic logic [DW-1:0] gray_to_bin(input logic [DW-1:0] g);
        for (int v = 0; v < (1 << DW); v++) begin
            if (DW'(v ^ (v >> 1)) == g) return DW'(v);
        end
        return '0;
    endfunction

    // Two words may be in flight; a full pipe accepts only if the head leaves.
    function automatic bit exp_ready();
        return (mq.size() < 2) || out_ready;
    endfunction

    function automatic bit exp_valid();
        return (mq.size() > 0) && (cyc - mq[0].acc >= 2);
    endfunction

    initial begin
        forever begin
            word_t w;
            bit    rdy, vis;
            @(posedge clk);
            rdy = exp_ready();
            vis = exp_valid();
            if (rst) begin
                mq.delete();
                m_hist_v  = 0;
                m_cnt     = 0;
                m_cnt_sat = 0;
                live      = 1;
            end else begin
                if (vis && out_ready) void'(mq.pop_front());
                if (in_valid && rdy) begin
                    w.acc = cyc;
                    if (mode) begin
                        w.data   = data_in ^ (data_in >> 1);
                        w.err    = 1'b0;
                        m_hist_v = 0;
                    end else begin
                        w.data   = gray_to_bin(data_in);
                        w.err    = m_hist_v && ($countones(data_in ^ m_hist) != 1);
                        m_hist   = data_in;
                        m_hist_v = 1;
                    end
                    if (w.err) begin
                        if (m_cnt < 255)   m_cnt++;
                        if (m_cnt_sat < 3) m_cnt_sat++;
                    end
                    mq.push_back(w);
                end
            end
            cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                check("in_ready", 32'(in_ready), 32'(exp_ready()));
                check("out_valid", 32'(out_valid), 32'(exp_valid()));
                check("err_cnt", 32'(err_cnt), 32'(m_cnt));
                check("sat_err_cnt", 32'(s_err_cnt), 32'(m_cnt_sat));
                check("nochk_out_valid", 32'(n_out_valid), 32'(exp_valid()));
                check("nochk_err_cnt", 32'(n_err_cnt), 32'd0);
                if (exp_valid()) begin
                    check("data_out", 32'(data_out), 32'(mq[0].data));
                    check("out_err", 32'(out_err), 32'(mq[0].err));
                    check("nochk_data_out", 32'(n_data_out), 32'(mq[0].data));
                    check("nochk_out_err", 32'(n_out_err), 32'd0);
                end
            end
        end
    end

    // Record of output transfers for the directed literal checks.
    logic [DW:0] cap[$];
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) cap.push_back({out_err, data_out});
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic m, input logic [DW-1:0] d);
        bit ok = 0;
        mode     = m;
        data_in  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cap.delete();
    endtask

    // Word sent last is expected on the output two edges after acceptance.
    task automatic expect2(input string name, input logic [DW-1:0] exp);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"}, 32'(data_out), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion within 200us");
        $fatal(1);
    end

    initial begin
        logic [DW:0]   exp_err[5];
        logic [DW:0]   exp_bp[6];
        logic [DW-1:0] sat_pat[5];
        int            sat_exp[5];
        int            nacc;
        bit            took, hv;
        logic [DW-1:0] held;
        time           t0, t1;

        // Reset with In_Valid asserted
        rst = 1'b1; in_valid = 1'b1; mode = 1'b1; data_in = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(1'b1, 4'b0011);
        expect2("post_rst", 4'b0010);

        // Basic conversions
        send(1'b0, 4'b0110);
        expect2("g2b_0110", 4'b0100);
        send(1'b1, 4'b1011);
        expect2("b2g_1011", 4'b1110);
        idle(2);

        // Full Gray sweep plus wrap, back-to-back
        do_reset();
        t0 = $time;
        for (int v = 0; v < 16; v++) send(1'b0, DW'(v ^ (v >> 1)));
        send(1'b0, 4'b0000);
        t1 = $time;
        idle(4);
        check("sweep_cycles", 32'((t1 - t0) / 10), 32'd17);
        check("sweep_count", 32'(cap.size()), 32'd17);
        for (int i = 0; i < 17 && i < cap.size(); i++)
            check("sweep_word", 32'(cap[i]), 32'(i % 16));
        check("sweep_err_cnt", 32'(err_cnt), 32'd0);

        // Sequence-error detection
        do_reset();
        send(1'b0, 4'b0000);
        send(1'b0, 4'b0011);
        check("err_cnt_after_dist2", 32'(err_cnt), 32'd1);
        send(1'b0, 4'b0011);
        check("err_cnt_after_repeat", 32'(err_cnt), 32'd2);
        send(1'b1, 4'b0101);
        send(1'b0, 4'b1111);
        idle(4);
        exp_err = '{5'b0_0000, 5'b1_0010, 5'b1_0010, 5'b0_0111, 5'b0_1010};
        check("err_count", 32'(cap.size()), 32'd5);
        for (int i = 0; i < 5 && i < cap.size(); i++)
            check("err_word", 32'(cap[i]), 32'(exp_err[i]));
        check("err_cnt_final", 32'(err_cnt), 32'd2);

        // Backpressure: Out_Ready low for 5 cycles with In_Valid high
        do_reset();
        out_ready = 1'b0;
        mode = 1'b1; data_in = 4'd1; in_valid = 1'b1;
        nacc = 0; hv = 0; held = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            took = in_ready;
            if (out_valid) begin
                if (hv) check("bp_hold", 32'(data_out), 32'(held));
                else begin held = data_out; hv = 1; end
            end
            @(posedge clk);
            #1;
            if (took) begin
                nacc++;
                data_in = DW'(nacc + 1);
            end
        end
        check("bp_accepted", 32'(nacc), 32'd2);
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head", 32'(data_out), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 3; k <= 6; k++) send(1'b1, DW'(k));
        idle(4);
        exp_bp = '{5'b0_0001, 5'b0_0011, 5'b0_0010, 5'b0_0110, 5'b0_0111, 5'b0_0101};
        check("bp_count", 32'(cap.size()), 32'd6);
        for (int i = 0; i < 6 && i < cap.size(); i++)
            check("bp_word", 32'(cap[i]), 32'(exp_bp[i]));

        // Saturation of the 2-bit counter
        do_reset();
        send(1'b0, 4'b0000);
        sat_pat = '{4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0011};
        sat_exp = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            send(1'b0, sat_pat[i]);
            check("sat_cnt", 32'(s_err_cnt), 32'(sat_exp[i]));
            check("wide_cnt", 32'(err_cnt), 32'(i + 1));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gray_bin_conv_pipe.md
Name: gray_bin_conv_pipe

Overview:
- Parametrised, pipelined, bidirectional Gray/binary code converter with valid/ready handshake on both sides.
- Per-transaction mode selects Gray->binary or binary->Gray conversion.
- In Gray->binary mode it also checks Gray-sequence integrity: consecutive accepted Gray words must differ in exactly one bit. Violations are flagged per word and counted.
- Sits between clock-domain-crossing pointer logic / encoder interfaces and binary consumers.

Parameters:
- DATA_WID, 4, width of data words; must be >= 2.
- CNT_WID, 8, width of the saturating error counter.
- CHECK_EN, 1, 1 = Gray-sequence checker enabled; 0 = Out_Err and Err_Cnt are held at 0.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- In_Valid  input  1  upstream word valid.
- In_Ready  output  1  block can accept a word this cycle.
- Mode  input  1  0 = Gray->binary, 1 = binary->Gray; sampled with Data_In.
- Data_In  input  DATA_WID  input word.
- Out_Valid  output  1  Data_Out valid.
- Out_Ready  input  1  downstream accepts Data_Out.
- Data_Out  output  DATA_WID  converted word.
- Out_Err  output  1  sequence error flag travelling with Data_Out.
- Err_Cnt  output  CNT_WID  saturating count of sequence errors.

Behaviour:
- Clock and reset: single clock Clk; reset Rst is synchronous and active-high.
- Reset values: In_Ready=1, Out_Valid=0, Data_Out=0, Out_Err=0, Err_Cnt=0. Both stage valids clear and the history-valid bit clears. A reset mid-operation discards all in-flight words.
- Transfers:
  - Input transfer when In_Valid && In_Ready.
  - Output transfer when Out_Valid && Out_Ready.
- Pipeline: two register stages, S1 then S2.
  - S1 captures Data_In, Mode and the error flag on an input transfer.
  - S2 holds the converted result and drives Data_Out/Out_Valid/Out_Err.
- Latency: a word accepted in cycle N appears on Data_Out in cycle N+2 with no backpressure. Throughput is 1 word/cycle.
- Ready and advance rules:
  - S2 loads when (!S2_valid || Out_Ready).
  - S1 advances into S2 under the same condition.
  - In_Ready = !S1_valid || (!S2_valid || Out_Ready). This is a combinational path from Out_Ready, by design.
- Hold rule: while Out_Valid && !Out_Ready, Data_Out, Out_Err and Out_Valid are held stable. No word is dropped or duplicated.
- Conversion:
  - Mode=1: out = in ^ (in >> 1).
  - Mode=0: out[DATA_WID-1] = in[DATA_WID-1]; out[i] = out[i+1] ^ in[i], computed in the S1->S2 path.
- Sequence checker (CHECK_EN=1):
  - A History register holds the last accepted Mode=0 word plus a History-valid bit.
  - On each accepted Mode=0 word, if History-valid and popcount(Data_In ^ History) != 1, that word's error flag = 1. This covers distance 0 (repeat) and distance >= 2.
  - Then History <= Data_In and History-valid <= 1.
  - The first Mode=0 word after reset, or after any Mode=1 word, is never flagged.
  - An accepted Mode=1 word clears History-valid and carries error flag 0.
  - Wrap-around (e.g. 1000 -> 0000 for width 4) is a legal single-bit step.
- Err_Cnt:
  - Increments by 1 in the cycle a flagged word is accepted at the input, not when it leaves the output.
  - Saturates at 2^CNT_WID-1. Cleared only by Rst.
- Simultaneous input and output transfer in the same cycle is legal and keeps full throughput.

Test Plan:
- Reset: assert Rst 2 cycles with In_Valid=1 -> Out_Valid=0, Err_Cnt=0, In_Ready=1. The first word after release is accepted and seen 2 cycles later.
- Basic conversion, DATA_WID=4, Out_Ready=1:
  - Mode=0, Data_In=0110 -> Data_Out=0100 after 2 cycles.
  - Mode=1, Data_In=1011 -> Data_Out=1110.
- Full sweep, Mode=0: stream the Gray codes of 0..15, then wrap to 0000 back-to-back -> Data_Out = 0,1,...,15,0; Out_Err=0 for all; Err_Cnt=0; one word per cycle.
- Error detection, Mode=0 stream:
  - Sequence 0000, 0011 -> second word Out_Err=1, Err_Cnt=1.
  - Repeat 0011 -> Out_Err=1, Err_Cnt=2.
  - Insert a Mode=1 word, then Mode=0 word 1111 -> no flag.
- Backpressure: hold Out_Ready=0 for 5 cycles with In_Valid=1 -> exactly 2 words accepted, then In_Ready=0; Data_Out stable throughout. Release -> the remaining words arrive in order with no loss or duplication.
- Saturation, CNT_WID=2: feed 5 flagged words -> Err_Cnt sequence 1,2,3,3,3.
